// File: rtl/gbt_replace_pkg.sv
// Shared definitions for the replace-mode spare-tile pool and its controller.
package gbt_replace_pkg;

  localparam int         DEF_TILE_POOL_SIZE = 64;
  localparam logic [8:0] DEF_TILE_POOL_BASE = 9'd320;
  localparam logic [3:0] REFCNT_MAX         = 4'd15;
  // Widest translation key an entry can hold; narrower keys are zero-extended.
  localparam int         KEY_MAX_W          = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SCAN,
    ALLOC,
    RESP,
    FLUSH
  } pool_state_t;

  typedef struct packed {
    logic                 valid;
    logic [KEY_MAX_W-1:0] key;
    logic [3:0]           refcnt;
    logic                 ref_bit;
  } pool_entry_t;

endpackage

// File: rtl/tile_pool_prio_enc.sv
// Lowest-index-set finder: used to pick the first free pool entry.
module tile_pool_prio_enc #(
  parameter int N     = 64,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tile_pool_alloc.sv
// Spare-tile pool allocator: key lookup, free-entry allocation and
// second-chance clock eviction, with per-cycle reference release.
module tile_pool_alloc
  import gbt_replace_pkg::*;
#(
  parameter int         TILE_POOL_SIZE = DEF_TILE_POOL_SIZE,
  parameter logic [8:0] TILE_POOL_BASE = DEF_TILE_POOL_BASE,
  parameter int         KEY_W          = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_enable,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [KEY_W-1:0]                  req_key,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [8:0]                        resp_tile,
  output logic                              resp_hit,
  output logic                              resp_new,
  output logic                              resp_fail,
  input  logic                              release_valid,
  input  logic [8:0]                        release_tile,
  input  logic                              flush,
  output logic [$clog2(TILE_POOL_SIZE):0]   pool_used,
  output logic                              pool_full
);

  localparam int              IDX_W     = $clog2(TILE_POOL_SIZE);
  localparam logic [IDX_W:0]  USED_MAX  = (IDX_W + 1)'(TILE_POOL_SIZE);
  // 2*SIZE-1: the last cycle of a full two-lap scan.
  localparam logic [IDX_W:0]  SCAN_LAST = '1;

  pool_entry_t               entries [TILE_POOL_SIZE];
  pool_state_t               state;
  logic [IDX_W-1:0]          hand, victim, hit_idx, free_idx, rel_idx;
  logic [IDX_W:0]            scan_cnt;
  logic                      victim_free, hit, free_found, flush_pend, rel_ok, scan_take;
  logic [KEY_W-1:0]          req_key_p0;
  logic [8:0]                res_tile;
  logic                      res_hit, res_new, res_fail;
  logic [TILE_POOL_SIZE-1:0] invalid_vec, inc_vec, dec_vec;
  logic [9:0]                rel_off;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == REFCNT_MAX) ? v : v + 4'd1;
  endfunction

  function automatic logic [8:0] tile_of(input logic [IDX_W-1:0] i);
    return TILE_POOL_BASE + 9'(i);
  endfunction

  assign req_ready = !rst && (state == IDLE) && cfg_enable && !flush_pend;
  assign pool_full = (pool_used == USED_MAX);
  assign scan_take = (entries[hand].refcnt == 4'd0) && !entries[hand].ref_bit;

  // Parallel key compare and free-entry vector across the whole pool.
  always_comb begin
    hit         = 1'b0;
    hit_idx     = '0;
    invalid_vec = '0;
    for (int i = TILE_POOL_SIZE - 1; i >= 0; i--) begin
      invalid_vec[i] = !entries[i].valid;
      if (entries[i].valid && entries[i].key == KEY_MAX_W'(req_key_p0)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Release decode: a release below BASE wraps negative and is rejected by bit 9.
  always_comb begin
    rel_off = {1'b0, release_tile} - {1'b0, TILE_POOL_BASE};
    rel_idx = rel_off[IDX_W-1:0];
    rel_ok  = release_valid && !rel_off[9] && (rel_off < 10'(TILE_POOL_SIZE)) &&
              entries[rel_idx].valid && (entries[rel_idx].refcnt != 4'd0);
  end

  // Per-entry increment/decrement strobes; both on one entry cancel out.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (state == LOOKUP && hit) inc_vec[hit_idx] = 1'b1;
    if (rel_ok) dec_vec[rel_idx] = 1'b1;
  end

  tile_pool_prio_enc #(.N(TILE_POOL_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .vec   (invalid_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  // Entry table update: flush/reset clear, refcounts, second-chance bits, allocation.
  always_ff @(posedge clk) begin
    if (rst || state == FLUSH) begin
      for (int i = 0; i < TILE_POOL_SIZE; i++) begin
        entries[i].valid   <= 1'b0;
        entries[i].refcnt  <= 4'd0;
        entries[i].ref_bit <= 1'b0;
      end
    end else begin
      for (int i = 0; i < TILE_POOL_SIZE; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          entries[i].refcnt <= sat_inc(entries[i].refcnt);
        else if (dec_vec[i] && !inc_vec[i])
          entries[i].refcnt <= entries[i].refcnt - 4'd1;
        if (inc_vec[i])
          entries[i].ref_bit <= 1'b1;
        else if (state == SCAN && hand == IDX_W'(i) && entries[i].refcnt == 4'd0)
          entries[i].ref_bit <= 1'b0;
        if (state == ALLOC && victim == IDX_W'(i)) begin
          entries[i].valid   <= 1'b1;
          entries[i].key     <= KEY_MAX_W'(req_key_p0);
          entries[i].refcnt  <= 4'd1;
          entries[i].ref_bit <= 1'b1;
        end
      end
    end
  end

  // Flush request latch; a new pulse during FLUSH re-arms it.
  always_ff @(posedge clk) begin
    if (rst)                 flush_pend <= 1'b0;
    else if (flush)          flush_pend <= 1'b1;
    else if (state == FLUSH) flush_pend <= 1'b0;
  end

  // Control FSM, clock hand, occupancy and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hand       <= '0;
      scan_cnt   <= '0;
      pool_used  <= '0;
      resp_valid <= 1'b0;
      resp_tile  <= '0;
      resp_hit   <= 1'b0;
      resp_new   <= 1'b0;
      resp_fail  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_pend)                   state <= FLUSH;
          else if (req_valid && req_ready)  state <= LOOKUP;
        end
        LOOKUP: begin
          scan_cnt <= '0;
          if (hit)             state <= RESP;
          else if (free_found) state <= ALLOC;
          else                 state <= SCAN;
        end
        SCAN: begin
          if (scan_take) begin
            state <= ALLOC;
          end else begin
            hand <= hand + 1'b1;
            if (scan_cnt == SCAN_LAST) state    <= RESP;
            else                       scan_cnt <= scan_cnt + 1'b1;
          end
        end
        ALLOC: begin
          hand <= victim + 1'b1;
          if (victim_free) pool_used <= pool_used + 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_tile  <= res_tile;
            resp_hit   <= res_hit;
            resp_new   <= res_new;
            resp_fail  <= res_fail;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_tile  <= '0;
            resp_hit   <= 1'b0;
            resp_new   <= 1'b0;
            resp_fail  <= 1'b0;
            state      <= IDLE;
          end
        end
        FLUSH: begin
          hand      <= '0;
          pool_used <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request key, victim choice and staged result; only meaningful while the FSM is busy.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (req_valid && req_ready) req_key_p0 <= req_key;
      LOOKUP: begin
        if (hit) begin
          res_tile <= tile_of(hit_idx);
          res_hit  <= 1'b1;
          res_new  <= 1'b0;
          res_fail <= 1'b0;
        end else if (free_found) begin
          victim      <= free_idx;
          victim_free <= 1'b1;
        end
      end
      SCAN: begin
        if (scan_take) begin
          victim      <= hand;
          victim_free <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
          res_tile <= '0;
          res_hit  <= 1'b0;
          res_new  <= 1'b0;
          res_fail <= 1'b1;
        end
      end
      ALLOC: begin
        res_tile <= tile_of(victim);
        res_hit  <= 1'b0;
        res_new  <= 1'b1;
        res_fail <= 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tile_pool_alloc.sv
// Bench for tile_pool_alloc: directed scenarios plus randomized traffic,
// all checked against a behavioural pool model.
module tb_tile_pool_alloc;

  localparam int S    = 64;
  localparam int BASE = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_key = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [8:0]  resp_tile;
  logic        resp_hit, resp_new, resp_fail;
  logic        release_valid = 1'b0;
  logic [8:0]  release_tile = '0;
  logic        flush = 1'b0;
  logic [6:0]  pool_used;
  logic        pool_full;

  int checks = 0;
  int errors = 0;

  // Behavioural pool model.
  bit          m_valid [S];
  logic [15:0] m_key   [S];
  int          m_cnt   [S];
  bit          m_ref   [S];
  int          m_hand;
  int          m_used;

  tile_pool_alloc #(.TILE_POOL_SIZE(S), .TILE_POOL_BASE(9'd320), .KEY_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_enable    (cfg_enable),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_key       (req_key),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_tile     (resp_tile),
    .resp_hit      (resp_hit),
    .resp_new      (resp_new),
    .resp_fail     (resp_fail),
    .release_valid (release_valid),
    .release_tile  (release_tile),
    .flush         (flush),
    .pool_used     (pool_used),
    .pool_full     (pool_full)
  );

  always #5 clk = ~clk;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void m_flush();
    for (int i = 0; i < S; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 0;
      m_ref[i]   = 1'b0;
    end
    m_hand = 0;
    m_used = 0;
  endfunction

  function automatic void m_alloc(input int i, input logic [15:0] key, output logic [8:0] tile);
    m_valid[i] = 1'b1;
    m_key[i]   = key;
    m_cnt[i]   = 1;
    m_ref[i]   = 1'b1;
    m_hand     = (i + 1) % S;
    tile       = 9'(BASE + i);
  endfunction

  // One request applied atomically; returns the expected response and latency.
  function automatic void m_request(input logic [15:0] key, output logic [8:0] tile,
                                    output bit hit, output bit nw, output bit fail,
                                    output int lat);
    tile = '0; hit = 1'b0; nw = 1'b0; fail = 1'b0; lat = 0;
    for (int i = 0; i < S; i++) begin
      if (m_valid[i] && m_key[i] == key) begin
        if (m_cnt[i] < 15) m_cnt[i]++;
        m_ref[i] = 1'b1;
        tile = 9'(BASE + i);
        hit  = 1'b1;
        lat  = 2;
        return;
      end
    end
    for (int i = 0; i < S; i++) begin
      if (!m_valid[i]) begin
        m_alloc(i, key, tile);
        m_used++;
        nw  = 1'b1;
        lat = 3;
        return;
      end
    end
    for (int c = 0; c < 2 * S; c++) begin
      int h;
      h = m_hand;
      if (m_cnt[h] == 0 && !m_ref[h]) begin
        m_alloc(h, key, tile);
        nw  = 1'b1;
        lat = 3 + c + 1;
        return;
      end
      if (m_cnt[h] == 0) m_ref[h] = 1'b0;
      m_hand = (h + 1) % S;
    end
    fail = 1'b1;
    lat  = 2 + 2 * S;
  endfunction

  function automatic void m_release(input logic [8:0] tile);
    int i;
    if (int'(tile) < BASE || int'(tile) >= BASE + S) return;
    i = int'(tile) - BASE;
    if (!m_valid[i] || m_cnt[i] == 0) return;
    m_cnt[i]--;
  endfunction

  // All driving tasks start and end #1 after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_flush();
  endtask

  task automatic do_release(input logic [8:0] tile);
    release_valid = 1'b1;
    release_tile  = tile;
    @(posedge clk); #1;
    release_valid = 1'b0;
    m_release(tile);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_flush();
  endtask

  task automatic do_req(input logic [15:0] key, input int stall, input bit with_rel,
                        input logic [8:0] rel_t, input int flush_at,
                        output logic [8:0] got_tile);
    int t, lat, elat;
    logic [8:0] etile;
    bit eh, en, ef;
    got_tile = '0;
    t = 0;
    while (!req_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL req_ready_wait: ready=%0b required 1", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_key   = key;
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_request(key, etile, eh, en, ef, elat);
    if (with_rel) begin
      release_valid = 1'b1;
      release_tile  = rel_t;
      m_release(rel_t);
    end
    lat = 0;
    while (!resp_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      release_valid = 1'b0;
      flush = 1'b0;
      if (lat == flush_at) flush = 1'b1;
    end
    flush = 1'b0;
    got_tile = resp_tile;
    checks++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL latency key=%h: got %0d required %0d", key, lat, elat);
    end
    checks++;
    if (resp_tile !== etile) begin
      errors++;
      $display("FAIL resp_tile key=%h: got %0d required %0d", key, resp_tile, etile);
    end
    checks++;
    if ({resp_hit, resp_new, resp_fail} !== {eh, en, ef}) begin
      errors++;
      $display("FAIL resp_flags key=%h: hit/new/fail got %b required %b",
               key, {resp_hit, resp_new, resp_fail}, {eh, en, ef});
    end
    checks++;
    if (pool_used !== 7'(m_used) || pool_full !== (m_used == S)) begin
      errors++;
      $display("FAIL pool_used key=%h: got %0d/%0b required %0d/%0b",
               key, pool_used, pool_full, m_used, (m_used == S));
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checks++;
      if (!resp_valid || resp_tile !== etile || {resp_hit, resp_new, resp_fail} !== {eh, en, ef}
          || req_ready) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: valid=%0b tile=%0d ready=%0b required 1/%0d/0",
                 s, resp_valid, resp_tile, req_ready, etile);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || resp_tile !== 9'd0) begin
      errors++;
      $display("FAIL resp_drop: valid=%0b tile=%0d required 0/0", resp_valid, resp_tile);
    end
    if (flush_at > 0) m_flush();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, resp_valid, resp_hit, resp_new, resp_fail, pool_full} !== 6'b0 ||
        resp_tile !== 9'd0 || pool_used !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b tile=%0d used=%0d required 0",
               {req_ready, resp_valid, resp_hit, resp_new, resp_fail, pool_full},
               resp_tile, pool_used);
    end
    rst = 1'b0;
    m_flush();
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b required 1", req_ready);
    end
  endtask

  task automatic test_basic();
    logic [8:0] t;
    do_reset();
    do_req(16'h1234, 0, 1'b0, 9'd0, -1, t);
    do_req(16'h1234, 1, 1'b0, 9'd0, -1, t);
  endtask

  task automatic test_second_chance();
    logic [8:0] t;
    do_reset();
    for (int i = 0; i < S; i++) do_req(16'h1000 + 16'(i), $urandom_range(0, 2), 1'b0, 9'd0, -1, t);
    do_release(9'd100);
    do_release(9'd325);
    do_release(9'd325);
    do_req(16'hBEEF, 0, 1'b0, 9'd0, -1, t);
    checks++;
    if (t !== 9'd325) begin
      errors++;
      $display("FAIL second_chance_tile: got %0d required 325", t);
    end
  endtask

  task automatic test_exhausted();
    logic [8:0] t;
    do_req(16'hCAFE, 0, 1'b0, 9'd0, -1, t);
  endtask

  task automatic test_same_cycle_release();
    logic [8:0] t;
    do_reset();
    do_req(16'h1234, 0, 1'b0, 9'd0, -1, t);
    do_req(16'h1234, 0, 1'b1, 9'd320, -1, t);
    do_release(9'd100);
    do_release(9'd320);
    do_release(9'd320);
    for (int i = 0; i < S - 1; i++) do_req(16'h2000 + 16'(i), 0, 1'b0, 9'd0, -1, t);
    do_req(16'h3000, 0, 1'b0, 9'd0, -1, t);
  endtask

  task automatic test_flush_scan();
    logic [8:0] t;
    do_release(9'd330);
    do_req(16'h4000, 0, 1'b0, 9'd0, 3, t);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_ready: got %0b required 0", req_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (pool_used !== 7'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: used=%0d ready=%0b required 0/1", pool_used, req_ready);
    end
    do_req(16'h4001, 0, 1'b0, 9'd0, -1, t);
    checks++;
    if (t !== 9'd320) begin
      errors++;
      $display("FAIL post_flush_tile: got %0d required 320", t);
    end
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready: got %0b required 0", req_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_flush();
    checks++;
    if (pool_used !== 7'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_used: used=%0d ready=%0b required 0/1", pool_used, req_ready);
    end
  endtask

  task automatic test_cfg_disable();
    cfg_enable = 1'b0;
    req_valid  = 1'b1;
    req_key    = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL cfg_disable: ready=%0b resp_valid=%0b required 0/0", req_ready, resp_valid);
      end
    end
    req_valid  = 1'b0;
    cfg_enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_alloc();
    logic [8:0] t;
    do_req(16'h4444, 0, 1'b0, 9'd0, -1, t);
    req_valid = 1'b1;
    req_key   = 16'h5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, resp_valid, resp_hit, resp_new, resp_fail, pool_full} !== 6'b0 ||
        resp_tile !== 9'd0 || pool_used !== 7'd0) begin
      errors++;
      $display("FAIL reset_in_alloc: ctl=%b tile=%0d used=%0d required 0",
               {req_ready, resp_valid, resp_hit, resp_new, resp_fail, pool_full},
               resp_tile, pool_used);
    end
    rst = 1'b0;
    m_flush();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0 || pool_used !== 7'd0) begin
        errors++;
        $display("FAIL no_resp_after_reset: valid=%0b used=%0d required 0/0", resp_valid, pool_used);
      end
    end
    do_req(16'h5555, 5, 1'b0, 9'd0, -1, t);
  endtask

  task automatic test_random();
    logic [8:0] t;
    int r;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 11)
        do_req(16'h5000 + 16'($urandom_range(0, 79)), $urandom_range(0, 2), 1'b0, 9'd0, -1, t);
      else if (r < 18)
        do_release(9'(BASE + $urandom_range(0, 69)));
      else if (r < 19)
        do_release(9'd100);
      else
        do_flush();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_second_chance();
    test_exhausted();
    test_same_cycle_release();
    test_flush_scan();
    test_flush_idle();
    test_cfg_disable();
    test_reset_in_alloc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
